// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path: buffer occupancy
// states and the bit positions of the {N,Z,C,V} flag nibble.
package alu_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/sub_result_stage_if.sv
// Bundle of the result stage's upstream beat, downstream result and sticky
// overflow signals.
//
// Handshake: a beat moves across a port on a rising edge where both valid and
// ready are high. A valid producer holds its data stable until that edge;
// ready may be asserted independently of valid.
interface sub_result_stage_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic             in_a_msb;
    logic             in_b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             clr_sticky;
    logic             sticky_v;

    // Producer/consumer side that surrounds the stage
    modport master (
        output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready, clr_sticky,
        input  in_ready, out_valid, out_result, out_flags, sticky_v
    );

    // The stage itself
    modport slave (
        input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready, clr_sticky,
        output in_ready, out_valid, out_result, out_flags, sticky_v
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} generation from an adder beat. The B operand MSB is
// the one the adder actually saw, so subtract overflow uses the same rule as add.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  sum_i,
    input  logic              cout_i,
    input  logic              a_msb_i,
    input  logic              b_msb_i,
    output logic [FLAG_W-1:0] flags_o
);

    // Overflow: operands of equal sign produced a result of the other sign
    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = sum_i[WIDTH-1];
        flags_o[FLAG_Z] = (sum_i == '0);
        flags_o[FLAG_C] = cout_i;
        flags_o[FLAG_V] = (a_msb_i == b_msb_i) && (sum_i[WIDTH-1] != a_msb_i);
    end

endmodule

// File: rtl/sub_result_stage.sv
// Registered result stage behind the subtractor: flags are computed on entry
// and stored with the sum in a two-entry skid buffer (main + skid), so every
// output and in_ready come straight from flops. Also tracks a sticky overflow
// bit for results that have left the stage.
module sub_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    sub_result_stage_if.slave   bus,
    output state_t              dbg_state_o
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_res_q, main_res_d;
    logic [WIDTH-1:0]   skid_res_q, skid_res_d;
    logic [FLAG_W-1:0]  main_flg_q, main_flg_d;
    logic [FLAG_W-1:0]  skid_flg_q, skid_flg_d;
    logic               in_ready_q, in_ready_d;
    logic               sticky_q, sticky_d;

    logic [FLAG_W-1:0]  in_flags;
    logic               out_valid;
    logic               accept;
    logic               pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .sum_i   (bus.in_sum),
        .cout_i  (bus.in_cout),
        .a_msb_i (bus.in_a_msb),
        .b_msb_i (bus.in_b_msb),
        .flags_o (in_flags)
    );

    // Decoded from the state register only; an illegal code reads as empty
    assign out_valid = (state_q == ONE) || (state_q == TWO);
    assign accept    = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // Buffer occupancy, data movement, registered in_ready and sticky overflow
    always_comb begin
        state_d    = state_q;
        main_res_d = main_res_q;
        main_flg_d = main_flg_q;
        skid_res_d = skid_res_q;
        skid_flg_d = skid_flg_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_res_d = bus.in_sum;
                    main_flg_d = in_flags;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_res_d = bus.in_sum;
                    main_flg_d = in_flags;
                end else if (accept) begin
                    skid_res_d = bus.in_sum;
                    skid_flg_d = in_flags;
                    state_d    = TWO;
                end else if (pop) begin
                    state_d    = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain can happen
                if (pop) begin
                    main_res_d = skid_res_q;
                    main_flg_d = skid_flg_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        in_ready_d = (state_d != TWO);

        // A departing overflow beat beats a simultaneous clear
        sticky_d = sticky_q;
        if (bus.clr_sticky) sticky_d = 1'b0;
        if (pop && main_flg_q[FLAG_V]) sticky_d = 1'b1;
    end

    // State register; reset empties the buffer and drops any held beats
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_res_q <= '0;
            main_flg_q <= '0;
            skid_res_q <= '0;
            skid_flg_q <= '0;
            in_ready_q <= 1'b1;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_res_q <= main_res_d;
            main_flg_q <= main_flg_d;
            skid_res_q <= skid_res_d;
            skid_flg_q <= skid_flg_d;
            in_ready_q <= in_ready_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = main_res_q;
    assign bus.out_flags  = main_flg_q;
    assign bus.sticky_v   = sticky_q;
    assign dbg_state_o    = state_q;

endmodule
